pcie_tx_arbiter: RTL and testbench
==================================

Name: pcie_tx_arbiter

Overview:
- Shares the single PCIe core transmit AXI-stream port (s_axis_tx) between two TLP sources.
  - Source 0: I/O completion engine.
  - Source 1: requester/interrupt TLP engine.
- Arbitrates per packet, round-robin, and holds the grant until the tlast beat.
- Registers the output stage and enforces a maximum packet length, using the core's discontinue signal on overrun.
- Sits between the TLP generators and the PCIe core's TX interface.

Parameters:
- C_DATA_WIDTH, 64, AXI-stream data width (64 only).
- KEEP_WIDTH, C_DATA_WIDTH/8, tkeep width.
- MAX_BEATS, 34, maximum beats per TLP: 16 B header plus 256 B payload, over 8 B beats.

Ports:
- i_clk  in  1  system bus clock; all logic on the rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_s0_tdata  in  C_DATA_WIDTH  source 0 data
- i_s0_tkeep  in  KEEP_WIDTH  source 0 keep
- i_s0_tlast  in  1  source 0 last beat
- i_s0_tvalid  in  1  source 0 valid
- o_s0_tready  out  1  source 0 ready
- i_s1_tdata, i_s1_tkeep, i_s1_tlast, i_s1_tvalid, o_s1_tready: same as source 0, for source 1.
- i_m_tready  in  1  core tready
- o_m_tdata  out  C_DATA_WIDTH  to core
- o_m_tkeep  out  KEEP_WIDTH  to core
- o_m_tlast  out  1  to core
- o_m_tvalid  out  1  to core
- o_m_src_dsc  out  1  discontinue, asserted with tlast of a truncated packet
- o_grant  out  2  one-hot current grant; 0 when idle
- o_err_overrun  out  1  one-cycle pulse when a packet is truncated

Behaviour:

Reset:
- i_rst=1 at a clock edge clears all registers.
- Resulting outputs: o_m_tvalid=0, o_m_tlast=0, o_m_src_dsc=0, o_m_tdata=0, o_m_tkeep=0, o_sN_tready=0, o_grant=0, o_err_overrun=0.
- Internal state after reset: state=IDLE, last_grant=1 (so source 0 wins first), beat_cnt=0.
- Reset mid-packet drops the packet immediately with no tlast; the core is also reset in that case.

Output register:
- Define accept_out = ~r.m_tvalid | i_m_tready.
- o_m_tvalid clears when i_m_tready=1 unless a new beat loads in the same cycle.
- Full throughput: one beat per cycle while the source is valid and the core is ready.

States:
- IDLE
  - o_sN_tready=0.
  - If any i_sN_tvalid=1, select a source:
    - only one valid: that source;
    - both valid: the source other than last_grant.
  - Register the grant and go to BUSY. Arbitration costs exactly 1 cycle.
  - No valid: stay in IDLE.
- BUSY
  - o_sG_tready = accept_out for the granted source G; the other source's tready=0.
  - On a beat (i_sG_tvalid & o_sG_tready):
    - load tdata/tkeep/tlast into the output register, set tvalid=1, beat_cnt++.
  - If the beat has tlast=1: last_grant=G, beat_cnt=0, go to IDLE.
  - Else if beat_cnt==MAX_BEATS-1 (this beat is number MAX_BEATS): force o_m_tlast=1 and o_m_src_dsc=1 on it, pulse o_err_overrun, go to DRAIN.
- DRAIN
  - o_sG_tready=1 unconditionally; accepted beats are discarded and never reach the output.
  - On the source tlast beat: last_grant=G, beat_cnt=0, go to IDLE.
  - Output register behaviour continues normally, so the truncated tlast still completes its handshake.

Other rules:
- o_m_src_dsc is valid only while o_m_tvalid=1 and must be 0 on every other beat.
- A single-beat packet (tlast on beat 1) is legal.
- If tlast and the MAX_BEATS limit coincide on the same beat, tlast wins: no dsc, no error.
- A new arbitration never starts until the previous packet's last beat has been accepted from the source. The output register may still hold that beat.
- A source dropping tvalid mid-packet does not release the grant.
- beat_cnt width is $clog2(MAX_BEATS+1) bits. The counter saturates and does not wrap; in DRAIN it is held.
- o_grant = registered grant in BUSY/DRAIN, 0 in IDLE.

Decomposition:
- pcie_cfg_pkg: add CFG_PCIE_TX_MAX_BEATS (34) as the default for MAX_BEATS.
- pcie_cfg_pkg: add the state encoding constants PCIE_TXARB_IDLE=2'd0, PCIE_TXARB_BUSY=2'd1, PCIE_TXARB_DRAIN=2'd2.
- Registers are held in one struct type local to the module, with the usual r/rin split.
- No sub-module. The round-robin selection is a few comb lines; a separate arbiter module is not warranted for two requesters.

Test Plan:
- Reset with both sources idle, then s0 sends a 3-beat CplD (tdata 0x11, 0x22, 0x33, tlast on beat 3) with i_m_tready=1 -> o_m_tvalid appears 2 cycles after the first s0 tvalid; data 0x11, 0x22, 0x33 in order; o_m_tlast only on 0x33; o_grant=01 during the packet.
- Both sources valid continuously, each sending 2-beat packets -> output packets alternate s0, s1, s0, s1; exactly one idle cycle between packets; no beat interleaving.
- i_m_tready toggles 1,0,0,1,1 during a 4-beat s1 packet -> no beat lost or duplicated; o_s1_tready low whenever the output register is full and tready=0; output tdata stable while stalled.
- s0 sends 40 beats with tlast only on beat 40 and MAX_BEATS=34 -> beat 34 output with tlast=1 and src_dsc=1, o_err_overrun pulses once; beats 35..40 consumed and not output; grant then moves to a waiting s1.
- s0 sends exactly 34 beats with tlast on beat 34 -> normal completion: src_dsc=0, no error pulse.
- i_rst asserted for 1 cycle during beat 2 of a 5-beat packet -> next cycle o_m_tvalid=0, o_grant=0, both treadys=0; afterwards s0 wins the first arbitration.

Source files
------------

// File: rtl/pcie_cfg_pkg.sv
// Shared PCIe configuration constants.
// Holds TX arbiter limits and its state encodings.
package pcie_cfg_pkg;

  // 16 B header + 256 B payload over 8 B beats
  localparam int CFG_PCIE_TX_MAX_BEATS = 34;

  localparam logic [1:0] PCIE_TXARB_IDLE  = 2'd0;
  localparam logic [1:0] PCIE_TXARB_BUSY  = 2'd1;
  localparam logic [1:0] PCIE_TXARB_DRAIN = 2'd2;

endpackage

// File: rtl/pcie_tx_arbiter.sv
// Two-source, per-packet round-robin arbiter onto the PCIe core TX stream.
// Ports: i_s0_*/i_s1_* sources, i_m_tready/o_m_* core side, o_grant, o_err_overrun.
module pcie_tx_arbiter
  import pcie_cfg_pkg::*;
#(
  parameter int C_DATA_WIDTH = 64,
  parameter int KEEP_WIDTH   = C_DATA_WIDTH / 8,
  parameter int MAX_BEATS    = CFG_PCIE_TX_MAX_BEATS
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [C_DATA_WIDTH-1:0] i_s0_tdata,
  input  logic [KEEP_WIDTH-1:0]   i_s0_tkeep,
  input  logic                    i_s0_tlast,
  input  logic                    i_s0_tvalid,
  output logic                    o_s0_tready,
  input  logic [C_DATA_WIDTH-1:0] i_s1_tdata,
  input  logic [KEEP_WIDTH-1:0]   i_s1_tkeep,
  input  logic                    i_s1_tlast,
  input  logic                    i_s1_tvalid,
  output logic                    o_s1_tready,
  input  logic                    i_m_tready,
  output logic [C_DATA_WIDTH-1:0] o_m_tdata,
  output logic [KEEP_WIDTH-1:0]   o_m_tkeep,
  output logic                    o_m_tlast,
  output logic                    o_m_tvalid,
  output logic                    o_m_src_dsc,
  output logic [1:0]              o_grant,
  output logic                    o_err_overrun
);

  localparam int CW = $clog2(MAX_BEATS + 1);

  typedef struct packed {
    logic [1:0]              state;
    logic                    gnt;
    logic                    last;
    logic [CW-1:0]           cnt;
    logic [C_DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0]   tkeep;
    logic                    tlast;
    logic                    tvalid;
    logic                    dsc;
    logic                    err;
  } reg_t;

  reg_t r, rin;

  logic                    accept;
  logic                    rdy;
  logic                    s_valid;
  logic                    s_last;
  logic [C_DATA_WIDTH-1:0] s_data;
  logic [KEEP_WIDTH-1:0]   s_keep;

  always_comb begin
    rin     = r;
    rin.err = 1'b0;
    rdy     = 1'b0;
    accept  = ~r.tvalid | i_m_tready;
    s_valid = r.gnt ? i_s1_tvalid : i_s0_tvalid;
    s_last  = r.gnt ? i_s1_tlast  : i_s0_tlast;
    s_data  = r.gnt ? i_s1_tdata  : i_s0_tdata;
    s_keep  = r.gnt ? i_s1_tkeep  : i_s0_tkeep;

    // held beat leaves; a new load below overrides
    if (i_m_tready)
      rin.tvalid = 1'b0;

    unique case (r.state)
      PCIE_TXARB_IDLE: begin
        if (i_s0_tvalid | i_s1_tvalid) begin
          rin.gnt   = (i_s0_tvalid & i_s1_tvalid) ? ~r.last
                                                  : i_s1_tvalid;
          rin.state = PCIE_TXARB_BUSY;
        end
      end
      PCIE_TXARB_BUSY: begin
        rdy = accept;
        if (s_valid & accept) begin
          rin.tdata  = s_data;
          rin.tkeep  = s_keep;
          rin.tlast  = s_last;
          rin.tvalid = 1'b1;
          rin.dsc    = 1'b0;
          if (s_last) begin
            rin.last  = r.gnt;
            rin.cnt   = '0;
            rin.state = PCIE_TXARB_IDLE;
          end else if (r.cnt == CW'(MAX_BEATS - 1)) begin
            // truncate: close the packet towards the core
            rin.tlast = 1'b1;
            rin.dsc   = 1'b1;
            rin.err   = 1'b1;
            rin.cnt   = CW'(MAX_BEATS);
            rin.state = PCIE_TXARB_DRAIN;
          end else if (r.cnt != CW'(MAX_BEATS)) begin
            rin.cnt = r.cnt + CW'(1);
          end
        end
      end
      PCIE_TXARB_DRAIN: begin
        // swallow the rest of the source packet
        rdy = 1'b1;
        if (s_valid & s_last) begin
          rin.last  = r.gnt;
          rin.cnt   = '0;
          rin.state = PCIE_TXARB_IDLE;
        end
      end
      default: rin.state = PCIE_TXARB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r      <= '0;
      r.last <= 1'b1;
    end else begin
      r <= rin;
    end
  end

  assign o_s0_tready   = rdy & ~r.gnt;
  assign o_s1_tready   = rdy & r.gnt;
  assign o_m_tdata     = r.tdata;
  assign o_m_tkeep     = r.tkeep;
  assign o_m_tlast     = r.tlast;
  assign o_m_tvalid    = r.tvalid;
  assign o_m_src_dsc   = r.dsc & r.tvalid;
  assign o_err_overrun = r.err;
  assign o_grant       = (r.state == PCIE_TXARB_IDLE) ? 2'b00
                                                     : {r.gnt, ~r.gnt};

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// Self-checking bench for pcie_tx_arbiter.
// Scoreboard queue of expected output beats plus per-scenario checks.
module tb_pcie_tx_arbiter;

  localparam int MAXB = 34;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic [63:0] i_s0_tdata = '0;
  logic [7:0]  i_s0_tkeep = '0;
  logic        i_s0_tlast = 1'b0;
  logic        i_s0_tvalid = 1'b0;
  logic        o_s0_tready;
  logic [63:0] i_s1_tdata = '0;
  logic [7:0]  i_s1_tkeep = '0;
  logic        i_s1_tlast = 1'b0;
  logic        i_s1_tvalid = 1'b0;
  logic        o_s1_tready;
  logic        i_m_tready = 1'b1;
  logic [63:0] o_m_tdata;
  logic [7:0]  o_m_tkeep;
  logic        o_m_tlast;
  logic        o_m_tvalid;
  logic        o_m_src_dsc;
  logic [1:0]  o_grant;
  logic        o_err_overrun;

  pcie_tx_arbiter dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_s0_tdata   (i_s0_tdata),
    .i_s0_tkeep   (i_s0_tkeep),
    .i_s0_tlast   (i_s0_tlast),
    .i_s0_tvalid  (i_s0_tvalid),
    .o_s0_tready  (o_s0_tready),
    .i_s1_tdata   (i_s1_tdata),
    .i_s1_tkeep   (i_s1_tkeep),
    .i_s1_tlast   (i_s1_tlast),
    .i_s1_tvalid  (i_s1_tvalid),
    .o_s1_tready  (o_s1_tready),
    .i_m_tready   (i_m_tready),
    .o_m_tdata    (o_m_tdata),
    .o_m_tkeep    (o_m_tkeep),
    .o_m_tlast    (o_m_tlast),
    .o_m_tvalid   (o_m_tvalid),
    .o_m_src_dsc  (o_m_src_dsc),
    .o_grant      (o_grant),
    .o_err_overrun(o_err_overrun)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic        s;
  } exp_t;

  exp_t q[$];

  int total = 0;
  int bad = 0;
  int err_cnt = 0;
  bit mon_en = 1'b1;
  bit chk_gap = 1'b0;
  bit chk_stall = 1'b0;
  bit gap_on = 1'b0;
  int gap = 0;
  bit prev_stall = 1'b0;
  logic [63:0] prev_data = '0;

  function automatic logic [63:0] dat(input logic [7:0] tag, input int i);
    return {tag, 56'(i + 1) * 56'h11};
  endfunction

  function automatic logic [7:0] kp(input int i, input int n);
    return (i == n - 1) ? 8'h0F : 8'hFF;
  endfunction

  function automatic logic rdy(input int src);
    return (src == 0) ? o_s0_tready : o_s1_tready;
  endfunction

  task automatic drive(input int src, input logic v, input logic [63:0] d,
                       input logic [7:0] k, input logic l);
    if (src == 0) begin
      i_s0_tvalid = v; i_s0_tdata = d; i_s0_tkeep = k; i_s0_tlast = l;
    end else begin
      i_s1_tvalid = v; i_s1_tdata = d; i_s1_tkeep = k; i_s1_tlast = l;
    end
  endtask

  // call at posedge+1; returns at posedge+1
  task automatic send(input int src, input int n, input logic [7:0] tag);
    for (int i = 0; i < n; i++) begin
      int t;
      drive(src, 1'b1, dat(tag, i), kp(i, n), i == n - 1);
      t = 0;
      do begin
        @(negedge i_clk);
        t++;
      end while (!rdy(src) && t < 300);
      if (!rdy(src)) begin
        total++; bad++;
        $display("FAIL send_timeout src=%0d beat=%0d", src, i);
      end
      @(posedge i_clk); #1;
    end
    drive(src, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic exp_pkt(input logic [7:0] tag, input int n);
    for (int i = 0; i < n && i < MAXB; i++) begin
      exp_t e;
      e.d = dat(tag, i);
      e.k = kp(i, n);
      e.l = (i == n - 1) || (i == MAXB - 1);
      e.s = (i == MAXB - 1) && (n > MAXB);
      q.push_back(e);
    end
  endtask

  task automatic wait_empty();
    int t = 0;
    while (q.size() != 0 && t < 500) begin
      @(negedge i_clk);
      t++;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain_queue left=%0d required=0", q.size());
    end
    repeat (3) @(posedge i_clk);
    #1;
  endtask

  always @(negedge i_clk) begin
    if (mon_en) begin
      if (o_err_overrun) err_cnt++;
      if (!o_m_tvalid) begin
        total++;
        if (o_m_src_dsc !== 1'b0) begin
          bad++;
          $display("FAIL dsc_idle got=%b required=0", o_m_src_dsc);
        end
      end
      if (chk_gap && gap_on) begin
        if (o_m_tvalid) begin
          total++;
          if (gap !== 1) begin
            bad++;
            $display("FAIL idle_gap got=%0d required=1", gap);
          end
          gap_on = 1'b0;
        end else begin
          gap++;
        end
      end
      if (chk_stall) begin
        if (prev_stall) begin
          total++;
          if (o_m_tdata !== prev_data) begin
            bad++;
            $display("FAIL stall_data got=%h required=%h", o_m_tdata, prev_data);
          end
        end
        if (o_m_tvalid && !i_m_tready) begin
          total++;
          if (o_s1_tready !== 1'b0) begin
            bad++;
            $display("FAIL stall_tready got=%b required=0", o_s1_tready);
          end
        end
      end
      prev_stall = o_m_tvalid && !i_m_tready;
      prev_data  = o_m_tdata;
      if (o_m_tvalid && i_m_tready) begin
        exp_t e, g;
        g = '{o_m_tdata, o_m_tkeep, o_m_tlast, o_m_src_dsc};
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL out_beat unexpected got=%h", g);
        end else begin
          e = q.pop_front();
          if (g !== e) begin
            bad++;
            $display("FAIL out_beat got d=%h k=%h l=%b s=%b required d=%h k=%h l=%b s=%b",
                     g.d, g.k, g.l, g.s, e.d, e.k, e.l, e.s);
          end
        end
        if (chk_gap && o_m_tlast) begin
          gap_on = 1'b1;
          gap = 0;
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    total += 8;
    if (o_m_tvalid !== 1'b0) begin bad++; $display("FAIL rst_tvalid got=%b required=0", o_m_tvalid); end
    if (o_m_tlast !== 1'b0) begin bad++; $display("FAIL rst_tlast got=%b required=0", o_m_tlast); end
    if (o_m_src_dsc !== 1'b0) begin bad++; $display("FAIL rst_dsc got=%b required=0", o_m_src_dsc); end
    if (o_m_tdata !== 64'h0) begin bad++; $display("FAIL rst_tdata got=%h required=0", o_m_tdata); end
    if (o_m_tkeep !== 8'h0) begin bad++; $display("FAIL rst_tkeep got=%h required=0", o_m_tkeep); end
    if ({o_s0_tready, o_s1_tready} !== 2'b00) begin
      bad++; $display("FAIL rst_tready got=%b%b required=00", o_s0_tready, o_s1_tready);
    end
    if (o_grant !== 2'b00) begin bad++; $display("FAIL rst_grant got=%b required=00", o_grant); end
    if (o_err_overrun !== 1'b0) begin bad++; $display("FAIL rst_err got=%b required=0", o_err_overrun); end
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(posedge i_clk); #1;
  endtask

  task automatic test_basic();
    int n = 0;
    exp_pkt(8'h00, 3);
    fork
      send(0, 3, 8'h00);
      begin
        do begin
          @(negedge i_clk);
          if (!o_m_tvalid) n++;
        end while (!o_m_tvalid && n < 20);
        total += 2;
        if (n !== 2) begin bad++; $display("FAIL latency got=%0d required=2", n); end
        if (o_grant !== 2'b01) begin bad++; $display("FAIL basic_grant got=%b required=01", o_grant); end
      end
    join
    wait_empty();
  endtask

  task automatic test_rr();
    do_reset();
    chk_gap = 1'b1;
    exp_pkt(8'hA0, 2);
    exp_pkt(8'hB0, 2);
    exp_pkt(8'hA1, 2);
    exp_pkt(8'hB1, 2);
    exp_pkt(8'hA2, 2);
    exp_pkt(8'hB2, 2);
    fork
      begin
        send(0, 2, 8'hA0);
        send(0, 2, 8'hA1);
        send(0, 2, 8'hA2);
      end
      begin
        send(1, 2, 8'hB0);
        send(1, 2, 8'hB1);
        send(1, 2, 8'hB2);
      end
    join
    wait_empty();
    chk_gap = 1'b0;
    gap_on = 1'b0;
  endtask

  task automatic test_stall();
    logic pat[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_pkt(8'hC5, 4);
    chk_stall = 1'b1;
    fork
      send(1, 4, 8'hC5);
      begin
        int t = 0;
        do begin
          @(negedge i_clk);
          t++;
        end while (!o_m_tvalid && t < 20);
        for (int i = 0; i < 5; i++) begin
          @(posedge i_clk); #1;
          i_m_tready = pat[i];
        end
        @(posedge i_clk); #1;
        i_m_tready = 1'b1;
      end
    join
    wait_empty();
    chk_stall = 1'b0;
  endtask

  task automatic test_overrun();
    int e0 = err_cnt;
    exp_pkt(8'hD0, 40);
    exp_pkt(8'hD1, 2);
    fork
      send(0, 40, 8'hD0);
      begin
        repeat (5) @(posedge i_clk);
        #1;
        send(1, 2, 8'hD1);
      end
    join
    wait_empty();
    total++;
    if (err_cnt - e0 !== 1) begin
      bad++; $display("FAIL overrun_err got=%0d required=1", err_cnt - e0);
    end
  endtask

  task automatic test_exact();
    int e0 = err_cnt;
    exp_pkt(8'hE0, MAXB);
    send(0, MAXB, 8'hE0);
    wait_empty();
    total++;
    if (err_cnt - e0 !== 0) begin
      bad++; $display("FAIL exact_err got=%0d required=0", err_cnt - e0);
    end
  endtask

  task automatic test_midreset();
    int t = 0;
    mon_en = 1'b0;
    q.delete();
    drive(0, 1'b1, dat(8'hF0, 0), 8'hFF, 1'b0);
    do begin
      @(negedge i_clk);
      t++;
    end while (!o_s0_tready && t < 20);
    @(posedge i_clk); #1;
    drive(0, 1'b1, dat(8'hF0, 1), 8'hFF, 1'b0);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    drive(0, 1'b0, '0, '0, 1'b0);
    @(negedge i_clk);
    total += 3;
    if (o_m_tvalid !== 1'b0) begin bad++; $display("FAIL mrst_tvalid got=%b required=0", o_m_tvalid); end
    if (o_grant !== 2'b00) begin bad++; $display("FAIL mrst_grant got=%b required=00", o_grant); end
    if ({o_s0_tready, o_s1_tready} !== 2'b00) begin
      bad++; $display("FAIL mrst_tready got=%b%b required=00", o_s0_tready, o_s1_tready);
    end
    @(posedge i_clk); #1;
    drive(0, 1'b1, dat(8'hF1, 0), 8'h0F, 1'b1);
    drive(1, 1'b1, dat(8'hF2, 0), 8'h0F, 1'b1);
    t = 0;
    do begin
      @(negedge i_clk);
      t++;
    end while (o_grant == 2'b00 && t < 20);
    total++;
    if (o_grant !== 2'b01) begin bad++; $display("FAIL mrst_first_grant got=%b required=01", o_grant); end
    t = 0;
    while (!o_s0_tready && t < 20) begin @(negedge i_clk); t++; end
    @(posedge i_clk); #1;
    drive(0, 1'b0, '0, '0, 1'b0);
    t = 0;
    do begin
      @(negedge i_clk);
      t++;
    end while (!o_s1_tready && t < 20);
    @(posedge i_clk); #1;
    drive(1, 1'b0, '0, '0, 1'b0);
    repeat (3) @(posedge i_clk);
    #1;
    mon_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rr();
    test_stall();
    test_overrun();
    test_exact();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
